// File: rtl/pipe_pkg.sv
// Shared definitions for the two-stage RV32I-subset pipeline: opcodes, ALU
// operation encoding, the canonical NOP and the ALU evaluation function.
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // 32-bit wrap-around ALU; shift amounts use only the low five bits of b.
  function automatic logic [XLEN-1:0] alu_fn(input alu_op_e op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// x0 always reads zero and discards writes.
module pipe_regfile
  import pipe_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            we_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i
);

  logic [XLEN-1:0] regs_q [0:31];
  logic [XLEN-1:0] regs_d [0:31];

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regs_q[rs2_addr_i];

  // Next register contents: apply the single write unless it targets x0.
  always_comb begin
    regs_d = regs_q;
    if (we_i && (rd_addr_i != 5'd0)) begin
      regs_d[rd_addr_i] = rd_data_i;
    end
  end

  // Register array with asynchronous clear of all entries.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/pipe_top.sv
// Two-stage RV32I-subset processor (IF | EX/MEM/WB) with on-chip instruction
// and data memories. Write-back completes in EX, so no forwarding or stalls
// are needed; a taken branch/jump flushes the single wrong-path fetch.
module pipe_top
  import pipe_pkg::*;
#(
  parameter int    IMEM_DEPTH = 1024,
  parameter int    DMEM_DEPTH = 1024,
  parameter string IMEM_FILE  = "instruction_memory.mem"
) (
  input logic clk_i,
  input logic rst_n_i
);

  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] imem [0:IMEM_DEPTH-1];
  logic [XLEN-1:0] dmem [0:DMEM_DEPTH-1];

  // Memory images at time zero: DMEM cleared, IMEM filled with NOP.
  initial begin
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = NOP;
  end

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_ex_instr_q, if_ex_instr_d;
  logic [XLEN-1:0] if_ex_pc_q, if_ex_pc_d;

  // Fetch: word index wraps because upper PC bits are ignored.
  logic [XLEN-1:0] instr;
  assign instr = imem[pc_q[IA_W+1:2]];

  // Instruction fields and immediates of the instruction in EX.
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = if_ex_instr_q[6:0];
  assign rd     = if_ex_instr_q[11:7];
  assign funct3 = if_ex_instr_q[14:12];
  assign rs1    = if_ex_instr_q[19:15];
  assign rs2    = if_ex_instr_q[24:20];
  assign funct7 = if_ex_instr_q[31:25];

  assign imm_i = {{20{if_ex_instr_q[31]}}, if_ex_instr_q[31:20]};
  assign imm_s = {{20{if_ex_instr_q[31]}}, if_ex_instr_q[31:25], if_ex_instr_q[11:7]};
  assign imm_b = {{19{if_ex_instr_q[31]}}, if_ex_instr_q[31], if_ex_instr_q[7],
                  if_ex_instr_q[30:25], if_ex_instr_q[11:8], 1'b0};
  assign imm_u = {if_ex_instr_q[31:12], 12'b0};
  assign imm_j = {{11{if_ex_instr_q[31]}}, if_ex_instr_q[31], if_ex_instr_q[19:12],
                  if_ex_instr_q[20], if_ex_instr_q[30:21], 1'b0};

  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;

  pipe_regfile u_rf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .we_i       (rf_we),
    .rd_addr_i  (rd),
    .rd_data_i  (rf_wdata)
  );

  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_b, alu_res;
  logic            alu_ok;

  // ALU control: only exact R/I encodings are legal; anything else leaves alu_ok low.
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = rs2_data;
    alu_ok = 1'b0;
    if (opcode == OP) begin
      alu_ok = 1'b1;
      case ({funct7, funct3})
        10'b0000000_000: alu_op = ALU_ADD;
        10'b0100000_000: alu_op = ALU_SUB;
        10'b0000000_001: alu_op = ALU_SLL;
        10'b0000000_010: alu_op = ALU_SLT;
        10'b0000000_011: alu_op = ALU_SLTU;
        10'b0000000_100: alu_op = ALU_XOR;
        10'b0000000_101: alu_op = ALU_SRL;
        10'b0100000_101: alu_op = ALU_SRA;
        10'b0000000_110: alu_op = ALU_OR;
        10'b0000000_111: alu_op = ALU_AND;
        default:         alu_ok = 1'b0;
      endcase
    end else if (opcode == OP_IMM) begin
      alu_b  = imm_i;
      alu_ok = 1'b1;
      case (funct3)
        3'b000:  alu_op = ALU_ADD;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b110:  alu_op = ALU_OR;
        3'b111:  alu_op = ALU_AND;
        3'b001: begin
          alu_op = ALU_SLL;
          alu_ok = (funct7 == 7'b0000000);
        end
        default: begin
          alu_op = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
          alu_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end
      endcase
    end
  end

  assign alu_res = alu_fn(alu_op, rs1_data, alu_b);

  // Data memory word address; byte offset bits are ignored.
  logic [XLEN-1:0] mem_addr;
  logic [DA_W-1:0] dmem_idx;
  logic            dmem_we;
  assign mem_addr = rs1_data + ((opcode == STORE) ? imm_s : imm_i);
  assign dmem_idx = mem_addr[DA_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[XLEN-1:DA_W+2], mem_addr[1:0]};

  logic            redirect;
  logic [XLEN-1:0] target;

  // Execute: register write-back, store enable and control-flow redirect.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    dmem_we  = 1'b0;
    redirect = 1'b0;
    target   = if_ex_pc_q + imm_b;
    case (opcode)
      OP, OP_IMM: rf_we = alu_ok;
      LOAD: begin
        rf_we    = (funct3 == 3'b010);
        rf_wdata = dmem[dmem_idx];
      end
      STORE: dmem_we = (funct3 == 3'b010);
      BRANCH: begin
        case (funct3)
          3'b000:  redirect = (rs1_data == rs2_data);
          3'b001:  redirect = (rs1_data != rs2_data);
          3'b100:  redirect = ($signed(rs1_data) <  $signed(rs2_data));
          3'b101:  redirect = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  redirect = (rs1_data <  rs2_data);
          3'b111:  redirect = (rs1_data >= rs2_data);
          default: redirect = 1'b0;
        endcase
      end
      JAL: begin
        rf_we    = 1'b1;
        rf_wdata = if_ex_pc_q + 32'd4;
        redirect = 1'b1;
        target   = if_ex_pc_q + imm_j;
      end
      JALR: begin
        rf_we    = (funct3 == 3'b000);
        rf_wdata = if_ex_pc_q + 32'd4;
        redirect = (funct3 == 3'b000);
        target   = (rs1_data + imm_i) & ~32'd1;
      end
      LUI: begin
        rf_we    = 1'b1;
        rf_wdata = imm_u;
      end
      AUIPC: begin
        rf_we    = 1'b1;
        rf_wdata = if_ex_pc_q + imm_u;
      end
      default: rf_we = 1'b0;
    endcase
  end

  // Word store on the clock edge; DMEM has no reset.
  always_ff @(posedge clk_i) begin
    if (dmem_we) dmem[dmem_idx] <= rs2_data;
  end

  // Next fetch state: a redirect wins over the sequential PC and squashes the fetched word.
  always_comb begin
    pc_d          = redirect ? target : pc_q + 32'd4;
    if_ex_instr_d = redirect ? NOP : instr;
    if_ex_pc_d    = pc_q;
  end

  // IF/EX pipeline registers and PC, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q          <= '0;
      if_ex_instr_q <= NOP;
      if_ex_pc_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      if_ex_instr_q <= if_ex_instr_d;
      if_ex_pc_q    <= if_ex_pc_d;
    end
  end

endmodule

// File: tb/tb_pipe_top.sv
// Bench for pipe_top: loads small hand-assembled programs into IMEM while in
// reset, runs them, and checks architectural state against hand-computed values.
module tb_pipe_top;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  pipe_top #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024), .IMEM_FILE("")) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] prog [0:63];
  int plen;

  typedef struct {
    bit          immf;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.u_rf.regs_q[i];
  endfunction

  // Instruction encoders (field values passed as ints, sliced here).
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input int opc);
    logic [31:0] v, r1, f, d, o;
    v = imm; r1 = rs1; f = f3; d = rd; o = opc;
    return {v[11:0], r1[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v, r1, r2;
    v = imm; r1 = rs1; r2 = rs2;
    return {v[11:5], r2[4:0], r1[4:0], 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input int f3);
    logic [31:0] v, r1, r2, f;
    v = imm; r1 = rs1; r2 = rs2; f = f3;
    return {v[12], v[10:5], r2[4:0], r1[4:0], f[2:0], v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int opc);
    logic [31:0] v, d, o;
    v = imm20; d = rd; o = opc;
    return {v[19:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v, d;
    v = imm; d = rd;
    return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6F};
  endfunction

  task automatic push(input logic [31:0] ins);
    prog[plen] = ins;
    plen++;
  endtask

  // Load a 32-bit constant with lui + addi (hi rounded to absorb the sign of lo).
  task automatic li(input int rd, input logic [31:0] val);
    logic [31:0] t;
    t = val + 32'h800;
    push(enc_u(int'(t[31:12]), rd, 7'h37));
    push(enc_i(int'(val[11:0]), rd, 0, rd, 7'h13));
  endtask

  // Reset the core, copy prog[] into IMEM (rest NOP), release on a falling edge.
  task automatic reset_load();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dut.imem[i] = (i < plen) ? prog[i] : 32'h0000_0013;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_alu_chain();
    plen = 0;
    push(enc_i(5, 0, 0, 1, 7'h13));
    push(enc_i(-3, 0, 0, 2, 7'h13));
    push({7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33});
    push({7'h20, 5'd2, 5'd1, 3'b000, 5'd4, 7'h33});
    push({7'h00, 5'd1, 5'd2, 3'b010, 5'd5, 7'h33});
  endtask

  initial begin
    logic [31:0] acc;
    logic [11:0] im;

    //            immf  f7     f3      a             b             expected
    vecs[0]  = '{1'b0, 7'h00, 3'b000, 32'd5,        32'hFFFFFFFD, 32'd2};
    vecs[1]  = '{1'b0, 7'h20, 3'b000, 32'd5,        32'hFFFFFFFD, 32'd8};
    vecs[2]  = '{1'b0, 7'h00, 3'b010, 32'hFFFFFFFD, 32'd5,        32'd1};
    vecs[3]  = '{1'b0, 7'h00, 3'b011, 32'hFFFFFFFD, 32'd5,        32'd0};
    vecs[4]  = '{1'b0, 7'h00, 3'b001, 32'd1,        32'd31,       32'h80000000};
    vecs[5]  = '{1'b0, 7'h00, 3'b001, 32'd1,        32'd33,       32'd2};
    vecs[6]  = '{1'b0, 7'h00, 3'b101, 32'h80000000, 32'd4,        32'h08000000};
    vecs[7]  = '{1'b0, 7'h20, 3'b101, 32'h80000000, 32'd4,        32'hF8000000};
    vecs[8]  = '{1'b0, 7'h00, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    vecs[9]  = '{1'b0, 7'h00, 3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
    vecs[10] = '{1'b0, 7'h00, 3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[11] = '{1'b0, 7'h00, 3'b000, 32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[12] = '{1'b0, 7'h20, 3'b000, 32'd0,        32'd1,        32'hFFFFFFFF};
    vecs[13] = '{1'b0, 7'h00, 3'b010, 32'd5,        32'hFFFFFFFD, 32'd0};
    vecs[14] = '{1'b1, 7'h00, 3'b000, 32'd5,        32'hFFFFFFFD, 32'd2};
    vecs[15] = '{1'b1, 7'h00, 3'b010, 32'hFFFFFFFD, 32'd5,        32'd1};
    vecs[16] = '{1'b1, 7'h00, 3'b011, 32'd5,        32'hFFFFFFFF, 32'd1};
    vecs[17] = '{1'b1, 7'h00, 3'b100, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000};
    vecs[18] = '{1'b1, 7'h00, 3'b110, 32'h12340000, 32'h000007FF, 32'h123407FF};
    vecs[19] = '{1'b1, 7'h00, 3'b111, 32'hFFFFFFFF, 32'hFFFFF800, 32'hFFFFF800};
    vecs[20] = '{1'b1, 7'h00, 3'b001, 32'd3,        32'd4,        32'h00000030};
    vecs[21] = '{1'b1, 7'h00, 3'b101, 32'hF0000000, 32'd28,       32'h0000000F};
    vecs[22] = '{1'b1, 7'h20, 3'b101, 32'hF0000000, 32'd28,       32'hFFFFFFFF};

    // Reset state and sequential fetch.
    #1 rst_n = 1'b0;
    plen = 0;
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0000_0013;
    step(1);
    check("reset_pc", dut.pc_q, 32'h0);
    check("reset_if_ex_instr", dut.if_ex_instr_q, 32'h0000_0013);
    check("reset_if_ex_pc", dut.if_ex_pc_q, 32'h0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc = acc | rf(i);
    check("reset_regs_or", acc, 32'h0);
    rst_n = 1'b1;
    step(1); check("pc_step1", dut.pc_q, 32'h4);
    step(1); check("pc_step2", dut.pc_q, 32'h8);
    step(1); check("pc_step3", dut.pc_q, 32'hC);
    check("if_ex_pc_step3", dut.if_ex_pc_q, 32'h8);

    // Dependent ALU chain with no stalls: slt retires on the sixth edge.
    load_alu_chain();
    reset_load();
    step(5);
    check("chain_x4_edge5", rf(4), 32'd8);
    check("chain_x5_not_yet", rf(5), 32'd0);
    step(1);
    check("chain_x3", rf(3), 32'd2);
    check("chain_x5", rf(5), 32'd1);

    // Table of ALU vectors: x1=a, x2=b, x3 = x1 op x2 (or x1 op imm).
    for (int v = 0; v < 23; v++) begin
      plen = 0;
      li(1, vecs[v].a);
      li(2, vecs[v].b);
      if (vecs[v].immf) begin
        im = (vecs[v].f3 == 3'b001 || vecs[v].f3 == 3'b101) ?
             {vecs[v].f7, vecs[v].b[4:0]} : vecs[v].b[11:0];
        push({im, 5'd1, vecs[v].f3, 5'd3, 7'h13});
      end else begin
        push({vecs[v].f7, 5'd2, 5'd1, vecs[v].f3, 5'd3, 7'h33});
      end
      reset_load();
      step(8);
      total_cnt++;
      if (rf(3) === vecs[v].exp) pass_cnt++;
      else $display("FAIL alu_vec%0d f7=%h f3=%0d: got %h expected %h",
                    v, vecs[v].f7, vecs[v].f3, rf(3), vecs[v].exp);
    end

    // Word loads/stores, store-then-load back to back, ignored byte offset.
    plen = 0;
    push(enc_i(32'h40, 0, 0, 1, 7'h13));
    push(enc_i(32'h7B, 0, 0, 2, 7'h13));
    push(enc_s(0, 2, 1));
    push(enc_i(0, 1, 2, 3, 7'h03));
    push(enc_i(3, 1, 2, 4, 7'h03));
    push(enc_s(-4, 1, 1));
    push(enc_i(-4, 1, 2, 5, 7'h03));
    reset_load();
    step(10);
    check("mem_dmem16", dut.dmem[16], 32'h7B);
    check("mem_lw_x3", rf(3), 32'h7B);
    check("mem_lw_offset3_x4", rf(4), 32'h7B);
    check("mem_dmem15", dut.dmem[15], 32'h40);
    check("mem_lw_neg_x5", rf(5), 32'h40);

    // Taken beq flushes the next fetch, one bubble.
    plen = 0;
    push(enc_b(8, 0, 0, 0));
    push(enc_i(1, 0, 0, 6, 7'h13));
    push(enc_i(2, 0, 0, 7, 7'h13));
    reset_load();
    step(2);
    check("beq_pc_redirect", dut.pc_q, 32'h8);
    check("beq_flush_nop", dut.if_ex_instr_q, 32'h0000_0013);
    step(1);
    check("beq_bubble_x7", rf(7), 32'd0);
    step(1);
    check("beq_x7", rf(7), 32'd2);
    check("beq_x6_flushed", rf(6), 32'd0);
    check("beq_pc_after", dut.pc_q, 32'h10);

    // Signed/unsigned branch conditions, taken and not taken.
    plen = 0;
    push(enc_i(-1, 0, 0, 1, 7'h13));   // 0x00 x1 = -1
    push(enc_b(8, 0, 1, 4));           // 0x04 blt x1,x0 taken
    push(enc_i(1, 0, 0, 9, 7'h13));    // 0x08 skipped
    push(enc_b(8, 0, 1, 6));           // 0x0C bltu x1,x0 not taken
    push(enc_i(1, 0, 0, 10, 7'h13));   // 0x10
    push(enc_b(8, 1, 0, 5));           // 0x14 bge x0,x1 taken
    push(enc_i(1, 0, 0, 11, 7'h13));   // 0x18 skipped
    push(enc_b(8, 0, 1, 1));           // 0x1C bne x1,x0 taken
    push(enc_i(1, 0, 0, 12, 7'h13));   // 0x20 skipped
    push(enc_b(8, 1, 0, 7));           // 0x24 bgeu x0,x1 not taken
    push(enc_i(1, 0, 0, 13, 7'h13));   // 0x28
    push(enc_b(8, 0, 1, 0));           // 0x2C beq x1,x0 not taken
    push(enc_i(1, 0, 0, 14, 7'h13));   // 0x30
    reset_load();
    step(25);
    check("blt_taken_x9", rf(9), 32'd0);
    check("bltu_not_taken_x10", rf(10), 32'd1);
    check("bge_taken_x11", rf(11), 32'd0);
    check("bne_taken_x12", rf(12), 32'd0);
    check("bgeu_not_taken_x13", rf(13), 32'd1);
    check("beq_not_taken_x14", rf(14), 32'd1);

    // Jumps, upper immediates, x0 writes and an unsupported encoding.
    plen = 0;
    push(32'h0000_0013);
    push(32'h0000_0013);
    push(32'h0000_0013);
    push(enc_u(32'h12345, 8, 7'h37));                   // 0x0C lui x8
    push(enc_j(8, 1));                                  // 0x10 jal x1,+8
    push(enc_i(1, 0, 0, 6, 7'h13));                     // 0x14 flushed
    push(enc_i(7, 0, 0, 0, 7'h13));                     // 0x18 addi x0,x0,7
    push(enc_u(1, 9, 7'h17));                           // 0x1C auipc x9,1
    push(enc_i(32'h30, 0, 0, 2, 7'h13));                // 0x20 x2 = 0x30
    push(enc_i(5, 2, 0, 3, 7'h67));                     // 0x24 jalr x3,5(x2)
    push(enc_i(1, 0, 0, 7, 7'h13));                     // 0x28 flushed
    push(enc_i(2, 0, 0, 7, 7'h13));                     // 0x2C skipped
    push(enc_i(3, 0, 0, 7, 7'h13));                     // 0x30 skipped
    push(enc_i(9, 0, 0, 10, 7'h13));                    // 0x34 x10 = 9
    push({7'h01, 5'd10, 5'd10, 3'b000, 5'd10, 7'h33});  // 0x38 mul: NOP here
    reset_load();
    step(6);
    check("jal_pc", dut.pc_q, 32'h18);
    check("jal_link_x1", rf(1), 32'h14);
    check("lui_x8", rf(8), 32'h12345000);
    step(20);
    check("jal_flushed_x6", rf(6), 32'd0);
    check("x0_stays_zero", rf(0), 32'd0);
    check("auipc_x9", rf(9), 32'h101C);
    check("jalr_link_x3", rf(3), 32'h28);
    check("jalr_skipped_x7", rf(7), 32'd0);
    check("unsupported_nop_x10", rf(10), 32'd9);

    // Asynchronous reset between edges, then re-execution from PC 0.
    load_alu_chain();
    reset_load();
    step(7);
    check("pre_reset_x5", rf(5), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", dut.pc_q, 32'h0);
    check("async_rst_instr", dut.if_ex_instr_q, 32'h0000_0013);
    check("async_rst_x3", rf(3), 32'd0);
    check("async_rst_x5", rf(5), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    check("rerun_x3", rf(3), 32'd2);
    check("rerun_x4", rf(4), 32'd8);
    check("rerun_x5", rf(5), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
